// File: rtl/fft_res_reader_pkg.sv
// Shared defaults and FSM encoding for the FFT result readout block.
package fft_pkg;

    localparam int IWL_DEF = 32;
    localparam int AWL_DEF = 7;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_FREE = 3'd1,
        S_FETCH     = 3'd2,
        S_HI        = 3'd3,
        S_LO        = 3'd4,
        S_FIN       = 3'd5
    } state_t;

endpackage

// File: rtl/fft_res_reader_if.sv
// RAM-side and stream-side signals of the FFT result reader.
interface fft_res_reader_if #(
    parameter int IWL = 32,
    parameter int AWL = 7
);
    logic           i_START;
    logic           i_RAM_BLOCK;
    logic [AWL-1:0] o_RAM_ADDR;
    logic           o_RAM_RD;
    logic [IWL-1:0] i_RAM_DATA;
    logic [15:0]    o_DATA;
    logic           o_VALID;
    logic           i_READY;
    logic           o_HALF;
    logic           o_LAST;
    logic           o_BUSY;
    logic           o_DONE;

    // Reader side: consumes requests/RAM data, produces the stream.
    modport slave (
        input  i_START, i_RAM_BLOCK, i_RAM_DATA, i_READY,
        output o_RAM_ADDR, o_RAM_RD, o_DATA, o_VALID, o_HALF, o_LAST, o_BUSY, o_DONE
    );

    // Environment side: FFT core/RAM and the sink.
    modport master (
        output i_START, i_RAM_BLOCK, i_RAM_DATA, i_READY,
        input  o_RAM_ADDR, o_RAM_RD, o_DATA, o_VALID, o_HALF, o_LAST, o_BUSY, o_DONE
    );
endinterface

// File: rtl/fft_res_reader_addr_gen.sv
// Frame index counter with optional bit-reversed RAM address.
module fft_addr_gen #(
    parameter int AWL    = 7,
    parameter int BITREV = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           inc,
    input  logic           clr,
    output logic [AWL-1:0] cnt,
    output logic [AWL-1:0] addr,
    output logic           last
);
    logic [AWL-1:0] cnt_q, cnt_d;

    // Index register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // Clear wins over increment; the terminal index never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)               cnt_d = '0;
        else if (inc && !last) cnt_d = cnt_q + 1'b1;
    end

    // Address is the index, optionally mirrored across AWL bits.
    always_comb begin
        addr = cnt_q;
        if (BITREV != 0) begin
            for (int i = 0; i < AWL; i++) addr[i] = cnt_q[AWL-1-i];
        end
    end

    assign cnt  = cnt_q;
    assign last = &cnt_q;
endmodule

// File: rtl/fft_res_reader.sv
// Reads one FFT frame out of RAM and streams it as Re/Im half-words.
//   state     | meaning
//   IDLE      | waiting for i_START
//   WAIT_FREE | waiting for the FFT core to release the RAM, then read
//   FETCH     | RAM data arrives, captured into word register
//   HI        | presenting Re half-word
//   LO        | presenting Im half-word (last one flagged)
//   FIN       | one-cycle done pulse
module fft_res_reader
    import fft_pkg::*;
#(
    parameter int IWL    = IWL_DEF,
    parameter int AWL    = AWL_DEF,
    parameter int BITREV = 0
) (
    input  logic               CLK,
    input  logic               RST,
    fft_res_reader_if.slave    bus
);
    state_t         state_q, state_d;
    logic [IWL-1:0] word_q, word_d;
    logic [AWL-1:0] addr_q, addr_d;
    logic [AWL-1:0] gen_cnt, gen_addr;
    logic           gen_last, gen_inc, gen_clr, rd;

    fft_addr_gen #(.AWL(AWL), .BITREV(BITREV)) u_addr_gen (
        .clk  (CLK),
        .rst_n(RST),
        .inc  (gen_inc),
        .clr  (gen_clr),
        .cnt  (gen_cnt),
        .addr (gen_addr),
        .last (gen_last)
    );

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Word and held-address registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            word_q <= '0;
            addr_q <= '0;
        end else begin
            word_q <= word_d;
            addr_q <= addr_d;
        end
    end

    // Next-state logic; RAM block is only looked at in WAIT_FREE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:      if (bus.i_START)     state_d = S_WAIT_FREE;
            S_WAIT_FREE: if (!bus.i_RAM_BLOCK) state_d = S_FETCH;
            S_FETCH:                          state_d = S_HI;
            S_HI:        if (bus.i_READY)     state_d = S_LO;
            S_LO:        if (bus.i_READY)     state_d = gen_last ? S_FIN : S_WAIT_FREE;
            S_FIN:                            state_d = S_IDLE;
            default:                          state_d = S_IDLE;
        endcase
    end

    // Counter control, data capture and address hold.
    always_comb begin
        rd      = (state_q == S_WAIT_FREE) && !bus.i_RAM_BLOCK;
        gen_clr = (state_q == S_IDLE) && bus.i_START;
        gen_inc = (state_q == S_LO) && bus.i_READY && !gen_last;
        word_d  = (state_q == S_FETCH) ? bus.i_RAM_DATA : word_q;
        addr_d  = rd ? gen_addr : addr_q;
    end

    // Outputs decoded from state; data is driven from the held word only.
    always_comb begin
        bus.o_BUSY     = (state_q != S_IDLE);
        bus.o_RAM_RD   = rd;
        bus.o_RAM_ADDR = rd ? gen_addr : addr_q;
        bus.o_VALID    = (state_q == S_HI) || (state_q == S_LO);
        bus.o_HALF     = (state_q == S_LO);
        bus.o_LAST     = (state_q == S_LO) && gen_last;
        bus.o_DONE     = (state_q == S_FIN);
        bus.o_DATA     = '0;
        if (state_q == S_HI) bus.o_DATA = word_q[IWL-1:IWL/2];
        if (state_q == S_LO) bus.o_DATA = word_q[IWL/2-1:0];
    end
endmodule

// File: tb/tb_fft_res_reader.sv
// Directed bench: linear and bit-reversed readout, sink stall, RAM block, mid-frame reset.
module tb_fft_res_reader;
    localparam int AWL = 3;

    logic CLK;
    logic RST;
    logic start, block, ready;
    logic [31:0] ram0_q, ram1_q;

    int checks = 0;
    int failures = 0;

    fft_res_reader_if #(.IWL(32), .AWL(AWL)) bus0 ();
    fft_res_reader_if #(.IWL(32), .AWL(AWL)) bus1 ();

    assign bus0.i_START = start;      assign bus1.i_START = start;
    assign bus0.i_RAM_BLOCK = block;  assign bus1.i_RAM_BLOCK = block;
    assign bus0.i_READY = ready;      assign bus1.i_READY = ready;
    assign bus0.i_RAM_DATA = ram0_q;  assign bus1.i_RAM_DATA = ram1_q;

    fft_res_reader #(.IWL(32), .AWL(AWL), .BITREV(0)) dut0 (.CLK(CLK), .RST(RST), .bus(bus0));
    fft_res_reader #(.IWL(32), .AWL(AWL), .BITREV(1)) dut1 (.CLK(CLK), .RST(RST), .bus(bus1));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] ram_word(input logic [2:0] a);
        return {16'h1000 + {13'd0, a}, 16'h2000 + {13'd0, a}};
    endfunction

    always @(posedge CLK) begin
        if (bus0.o_RAM_RD) ram0_q <= ram_word(bus0.o_RAM_ADDR);
        if (bus1.o_RAM_RD) ram1_q <= ram_word(bus1.o_RAM_ADDR);
    end

    // Monitor: samples each cycle in its second half, after inputs have settled.
    int cyc = 0;
    logic [17:0] hs0[$];
    logic [15:0] hs1[$];
    logic [2:0]  rdq0[$], rdq1[$];
    int first_rd, first_vld, last_hs, done_cyc, done_cnt;

    always @(negedge CLK) begin
        #1;
        cyc = cyc + 1;
        if (RST) begin
            if (bus0.o_RAM_RD) begin
                rdq0.push_back(bus0.o_RAM_ADDR);
                if (first_rd < 0) first_rd = cyc;
            end
            if (bus0.o_VALID && first_vld < 0) first_vld = cyc;
            if (bus0.o_VALID && ready) begin
                hs0.push_back({bus0.o_LAST, bus0.o_HALF, bus0.o_DATA});
                last_hs = cyc;
            end
            if (bus0.o_DONE) begin
                done_cyc = cyc;
                done_cnt = done_cnt + 1;
            end
            if (bus1.o_RAM_RD) rdq1.push_back(bus1.o_RAM_ADDR);
            if (bus1.o_VALID && ready) hs1.push_back(bus1.o_DATA);
        end
    end

    task automatic clear_mon();
        hs0.delete(); hs1.delete(); rdq0.delete(); rdq1.delete();
        first_rd = -1; first_vld = -1; last_hs = -1; done_cyc = -1; done_cnt = 0;
    endtask

    // Number of entries among the first n of hs0 that differ from the linear frame.
    function automatic int prefix_errs(input int n);
        int errs = 0;
        logic [17:0] e;
        if (hs0.size() < n) return 99;
        for (int i = 0; i < n; i++) begin
            e[17]   = (i == 15);
            e[16]   = (i % 2 == 1);
            e[15:0] = ((i % 2 == 1) ? 16'h2000 : 16'h1000) + 16'(i / 2);
            if (hs0[i] !== e) errs++;
        end
        return errs;
    endfunction

    function automatic int seq0_errs();
        if (hs0.size() != 16) return 99;
        return prefix_errs(16);
    endfunction

    task automatic start_pulse(output int scyc);
        @(negedge CLK);
        start = 1'b1;
        scyc = cyc + 1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            if (done_cnt > 0) begin seen = 1; break; end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL wait_done: o_DONE not seen within %0d cycles", budget);
        end
        for (int i = 0; i < 60; i++) begin
            if (!bus0.o_BUSY && !bus1.o_BUSY) break;
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        RST = 1'b0; start = 1'b0; block = 1'b0; ready = 1'b1;
        clear_mon();
        repeat (3) @(negedge CLK);
        checks++;
        if ({bus0.o_BUSY, bus0.o_VALID, bus0.o_RAM_RD, bus0.o_DONE, bus0.o_LAST, bus0.o_HALF,
             bus0.o_DATA, bus0.o_RAM_ADDR} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b valid=%b rd=%b data=%h addr=%0d, required all zero",
                     bus0.o_BUSY, bus0.o_VALID, bus0.o_RAM_RD, bus0.o_DATA, bus0.o_RAM_ADDR);
        end
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if (bus0.o_BUSY !== 1'b0 || bus1.o_BUSY !== 1'b0 || rdq0.size() != 0) begin
            failures++;
            $display("FAIL reset_idle: busy0=%b busy1=%b reads=%0d, required idle with no reads",
                     bus0.o_BUSY, bus1.o_BUSY, rdq0.size());
        end
    endtask

    task automatic test_linear();
        int s, errs;
        logic [2:0] exp_br [8];
        exp_br = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
        clear_mon();
        start_pulse(s);
        wait_done(80);
        errs = seq0_errs();
        checks++;
        if (errs !== 0) begin
            failures++;
            $display("FAIL linear_seq: %0d bad half-words of %0d, required 16 matching", errs, hs0.size());
        end
        checks++;
        if (first_rd !== s + 1) begin
            failures++;
            $display("FAIL linear_rd_latency: first read cycle %0d, required %0d", first_rd, s + 1);
        end
        checks++;
        if (first_vld !== s + 3) begin
            failures++;
            $display("FAIL linear_vld_latency: first valid cycle %0d, required %0d", first_vld, s + 3);
        end
        checks++;
        if (last_hs - first_rd + 1 !== 32) begin
            failures++;
            $display("FAIL linear_duration: %0d cycles, required 32", last_hs - first_rd + 1);
        end
        checks++;
        if (done_cyc !== last_hs + 1 || done_cnt !== 1) begin
            failures++;
            $display("FAIL linear_done: done at %0d count %0d, required at %0d count 1",
                     done_cyc, done_cnt, last_hs + 1);
        end
        errs = 0;
        if (rdq0.size() != 8) errs = 99;
        else for (int i = 0; i < 8; i++) if (rdq0[i] !== 3'(i)) errs++;
        checks++;
        if (errs !== 0) begin
            failures++;
            $display("FAIL linear_addr: %0d bad addresses of %0d, required 0..7", errs, rdq0.size());
        end
        errs = 0;
        if (rdq1.size() != 8) errs = 99;
        else for (int i = 0; i < 8; i++) if (rdq1[i] !== exp_br[i]) errs++;
        checks++;
        if (errs !== 0) begin
            failures++;
            $display("FAIL bitrev_addr: %0d bad addresses of %0d, required 0,4,2,6,1,5,3,7", errs, rdq1.size());
        end
        checks++;
        if (hs1.size() != 16 || hs1[1] !== 16'h2000 || hs1[2] !== 16'h1004) begin
            failures++;
            $display("FAIL bitrev_data: count %0d, required 16 with [1]=2000 [2]=1004", hs1.size());
        end
    endtask

    task automatic test_stall();
        int s, bad, rd_before;
        bit found = 0;
        clear_mon();
        start_pulse(s);
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (bus0.o_VALID && !bus0.o_HALF && bus0.o_DATA == 16'h1002) begin found = 1; break; end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL stall_reach: HI of word 2 not observed, required within 40 cycles");
        end
        ready = 1'b0;
        rd_before = rdq0.size();
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge CLK);
            if (bus0.o_DATA !== 16'h1002 || bus0.o_VALID !== 1'b1 || bus0.o_HALF !== 1'b0 ||
                bus0.o_LAST !== 1'b0 || bus0.o_RAM_RD !== 1'b0) bad++;
        end
        @(negedge CLK);
        checks++;
        if (bad !== 0 || rdq0.size() != rd_before || hs0.size() != 4) begin
            failures++;
            $display("FAIL stall_hold: %0d unstable cycles, reads %0d->%0d, accepted %0d, required 0, no reads, 4",
                     bad, rd_before, rdq0.size(), hs0.size());
        end
        ready = 1'b1;
        wait_done(80);
        checks++;
        if (seq0_errs() !== 0) begin
            failures++;
            $display("FAIL stall_seq: %0d bad half-words of %0d, required 16 matching", seq0_errs(), hs0.size());
        end
    endtask

    task automatic test_block();
        int s, bad, x;
        bit found = 0;
        clear_mon();
        block = 1'b1;
        start_pulse(s);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge CLK);
            if (bus0.o_RAM_RD !== 1'b0 || bus0.o_BUSY !== 1'b1) bad++;
        end
        @(negedge CLK);
        block = 1'b0;
        x = cyc + 1;
        @(negedge CLK);
        checks++;
        if (bad !== 0 || first_rd !== x) begin
            failures++;
            $display("FAIL block_start: %0d bad blocked cycles, first read %0d, required 0 and %0d", bad, first_rd, x);
        end
        for (int i = 0; i < 40; i++) begin
            if (bus0.o_VALID && !bus0.o_HALF && bus0.o_DATA == 16'h1003) begin found = 1; break; end
            @(negedge CLK);
        end
        block = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (bus0.o_RAM_RD !== 1'b0) bad++;
        end
        checks++;
        if (!found || bad !== 0 || hs0.size() != 8 || prefix_errs(8) !== 0) begin
            failures++;
            $display("FAIL block_mid: found=%0d reads=%0d accepted=%0d, required word 3 complete and no fetch",
                     found, bad, hs0.size());
        end
        block = 1'b0;
        wait_done(80);
        checks++;
        if (seq0_errs() !== 0 || rdq0.size() != 8) begin
            failures++;
            $display("FAIL block_seq: %0d bad half-words, %0d reads, required 0 and 8", seq0_errs(), rdq0.size());
        end
    endtask

    task automatic test_reset_mid();
        int s, bad;
        bit found = 0;
        clear_mon();
        start_pulse(s);
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (hs0.size() >= 4) break;
        end
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus0.o_VALID && bus0.o_HALF && bus0.o_DATA == 16'h2005) begin found = 1; break; end
            @(negedge CLK);
        end
        checks++;
        if (!found || hs0.size() != 11 || prefix_errs(11) !== 0) begin
            failures++;
            $display("FAIL busy_start_ignored: found=%0d accepted=%0d, required LO of word 5 after 11 clean half-words",
                     found, hs0.size());
        end
        #2;
        RST = 1'b0;
        #1;
        checks++;
        if ({bus0.o_BUSY, bus0.o_VALID, bus0.o_RAM_RD, bus0.o_DONE, bus0.o_LAST, bus0.o_HALF,
             bus0.o_DATA, bus0.o_RAM_ADDR, bus1.o_BUSY, bus1.o_VALID} !== '0) begin
            failures++;
            $display("FAIL async_reset: busy=%b valid=%b last=%b half=%b data=%h addr=%0d, required all zero",
                     bus0.o_BUSY, bus0.o_VALID, bus0.o_LAST, bus0.o_HALF, bus0.o_DATA, bus0.o_RAM_ADDR);
        end
        @(negedge CLK);
        RST = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (bus0.o_BUSY !== 1'b0 || bus0.o_RAM_RD !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL post_reset_idle: %0d busy cycles without start, required 0", bad);
        end
        clear_mon();
        start_pulse(s);
        wait_done(80);
        checks++;
        if (rdq0.size() == 0 || rdq0[0] !== 3'd0 || seq0_errs() !== 0) begin
            failures++;
            $display("FAIL restart: reads=%0d first=%0d bad=%0d, required first address 0 and clean frame",
                     rdq0.size(), (rdq0.size() > 0) ? rdq0[0] : 3'd7, seq0_errs());
        end
    endtask

    initial begin
        test_reset();
        test_linear();
        test_stall();
        test_block();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fft_res_reader.md
FFT_RES_READER -- requirements
Module: fft_res_reader

Interface
REQ-001 SHALL have parameter IWL, default 32, RAM word width: {Re[IWL-1:IWL/2], Im[IWL/2-1:0]}; only IWL=32 supported.
REQ-002 SHALL have parameter AWL, default 7, RAM address width; frame length N = 2^AWL words.
REQ-003 SHALL have parameter BITREV, default 0; when 1, RAM address is the bit-reversed frame index.
REQ-004 SHALL have the ports below.
- CLK  input  1  sole clock, rising edge.
- RST  input  1  asynchronous, active-low reset.
- i_START  input  1  one-cycle request to read out one frame.
- i_RAM_BLOCK  input  1  FFT core owns the RAM while high.
- o_RAM_ADDR  output  AWL  RAM read address.
- o_RAM_RD  output  1  RAM read strobe, one cycle per word.
- i_RAM_DATA  input  IWL  RAM read data, valid exactly one cycle after o_RAM_RD.
- o_DATA  output  16  output half-word.
- o_VALID  output  1  o_DATA valid.
- i_READY  input  1  sink accepts o_DATA.
- o_HALF  output  1  0 = Re half, 1 = Im half.
- o_LAST  output  1  marks the final half-word of the frame.
- o_BUSY  output  1  readout in progress.
- o_DONE  output  1  one-cycle pulse after the frame completes.

Function
REQ-005 SHALL implement the FSM IDLE, WAIT_FREE, FETCH, HI, LO, FIN.
REQ-006 IDLE: o_BUSY=0; i_START=1 -> clear index cnt to 0, go to WAIT_FREE.
REQ-007 WAIT_FREE: while i_RAM_BLOCK=1, hold with o_RAM_RD=0; when i_RAM_BLOCK=0, assert o_RAM_RD=1 with o_RAM_ADDR=f(cnt) for that cycle only, go to FETCH.
REQ-008 f(cnt) SHALL be cnt for BITREV=0 and bit-reversed cnt over AWL bits for BITREV=1.
REQ-009 FETCH: capture i_RAM_DATA into the word register at the closing edge, go to HI.
REQ-010 HI: o_VALID=1, o_DATA=word[31:16], o_HALF=0; on o_VALID&i_READY go to LO.
REQ-011 LO: o_VALID=1, o_DATA=word[15:0], o_HALF=1, o_LAST=(cnt==N-1); on handshake go to FIN if last, else cnt+1 and go to WAIT_FREE.
REQ-012 FIN: o_DONE=1 for one cycle, go to IDLE.
REQ-013 o_BUSY SHALL be 1 in every state except IDLE.
REQ-014 While o_VALID=1 and i_READY=0, o_DATA, o_HALF and o_LAST SHALL hold stable.
REQ-015 Throughput SHALL be 4 cycles per word with i_READY=1 and i_RAM_BLOCK=0.
- Latency: i_START sampled at edge k -> o_RAM_RD high in cycle k+1 -> first o_VALID in cycle k+3.
REQ-016 i_START SHALL be ignored when o_BUSY=1.
REQ-017 i_RAM_BLOCK SHALL be sampled only in WAIT_FREE; a word already fetched SHALL complete output even if i_RAM_BLOCK rises.
REQ-018 cnt SHALL be AWL bits and never wrap within a frame; N-1 is terminal.
REQ-019 o_RAM_ADDR SHALL hold its last value outside the o_RAM_RD cycle.

Reset
REQ-020 RST=0 SHALL, asynchronously and from any state including mid-frame, force state IDLE, cnt=0, word=0, and all outputs 0; no pending handshake survives reset.
REQ-021 After RST deasserts, the block SHALL need a fresh i_START to begin readout.

Structure
REQ-022 IWL/AWL defaults and FSM state encoding SHALL live in shared package fft_pkg.
REQ-023 The index counter plus bit-reversal SHALL be one sub-module, fft_addr_gen (inc, clr, cnt, addr, last).

Verification
REQ-024 AWL=3, BITREV=0, RAM[i]={16'h1000+i, 16'h2000+i}, i_READY=1, START -> 16 half-words 1000,2000,1001,2001,...,1007,2007; o_LAST only on 2007; o_DONE 1 cycle later; 32 cycles total.
REQ-025 Same setup with BITREV=1 -> addresses 0,4,2,6,1,5,3,7; first Im word is 2000, second Re word is 1004.
REQ-026 i_READY low for 5 cycles in HI of word 2 -> o_DATA=1002 held stable, no RAM read issued, sequence otherwise unchanged.
REQ-027 i_RAM_BLOCK=1 at START for 10 cycles -> no o_RAM_RD until i_RAM_BLOCK falls; BLOCK rising during HI of word 3 -> word 3 completes, word 4 fetch waits.
REQ-028 RST=0 asynchronously during word 5 LO -> all outputs 0 immediately; second START during busy ignored; after reset, new START reads from address 0.
